clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Multi-channel, run-time programmable clock divider; generalises the fixed-parameter divider.
//  Each of N_CH channels derives a square wave and a 1-cycle tick (clock enable) from clk.
//  Divisors load through a valid/ready config port and apply glitch-free at a period boundary.
//  Feeds slow-strobe consumers (pipeline stage enables, LED/display refresh) in the adder design.
// PARAMETERS
//  N_CH         4   number of independent channels (>=1)
//  CNT_W        32  counter/divisor width in bits
//  DEFAULT_DIV  2   divisor loaded into every channel at reset (out period = 2*DEFAULT_DIV)
//  (local) CH_W = (N_CH>1) ? $clog2(N_CH) : 1
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst_n      in   1      synchronous, active-low reset
//  en         in   N_CH   per-channel run enable
//  cfg_valid  in   1      config request valid
//  cfg_ready  out  1      config accepted when cfg_valid & cfg_ready
//  cfg_ch     in   CH_W   target channel; values >= N_CH are accepted and dropped
//  cfg_div    in   CNT_W  new divisor D; D=0 halts the channel
//  clk_out    out  N_CH   divided square wave per channel (registered)
//  tick       out  N_CH   1-cycle pulse on every clk_out toggle (registered)
//  pend       out  N_CH   per-channel "new divisor pending" status
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): cnt=0, clk_out=0, tick=0, pend=0, div=DEFAULT_DIV all channels.
//  Per channel, active divisor D, counter cnt:
//   - en=1, D>=1: cnt increments each cycle; when cnt==D-1 -> cnt<=0, clk_out toggles,
//     tick<=1 for that cycle (wrap). Otherwise tick<=0.
//   - Period of clk_out = 2*D cycles, 50% duty. D=1 -> clk_out toggles every cycle.
//   - First toggle after reset/enable occurs D cycles after first enabled edge.
//   - en=0: cnt<=0, clk_out<=0, tick<=0 next cycle; counting restarts from 0 on re-enable.
//   - D=0: channel halted, cnt<=0, clk_out held at current value, tick<=0.
//  Config handshake:
//   - cfg_ready = ~pend[cfg_ch] (combinational on cfg_ch); always 1 for cfg_ch >= N_CH.
//   - Accept: shadow[ch]<=cfg_div, pend[ch]<=1. One outstanding update per channel.
//   - Apply at next wrap edge of that channel: div<=shadow, cnt<=0, pend<=0; clk_out still
//     toggles on that wrap, so no runt pulse. New period starts the following cycle.
//   - Channel disabled or halted (en=0 or D=0): apply on the cycle after accept.
//   - Accept on the same cycle as a wrap: value goes to shadow, applied at the following wrap.
//   - cfg_valid with cfg_ready=0: no state change; master holds request.
//  Arithmetic: cnt compare in CNT_W bits unsigned; no overflow since cnt < D <= 2^CNT_W-1.
//  Reset mid-operation: discards pending updates; all channels return to DEFAULT_DIV.
// CONFIGURATION
//  CLK_DIV_SYNC_EN defined: adds input sync_req (1). When sync_req=1 at posedge, every
//   enabled channel with D>=1: cnt<=0, clk_out<=0, tick<=0, and any pending divisor applied.
//   This phase-aligns all channels. sync_req has priority over wrap; reset over sync_req.
//  CLK_DIV_SYNC_EN undefined: port absent; channels free-run, phases independent.
// TESTING
//  1. Reset, en=4'hF, no cfg -> all clk_out toggle every 2 cycles, tick every 2 cycles, pend=0.
//  2. cfg ch1 D=5 mid-period -> pend[1]=1 until next ch1 wrap. Then clk_out[1] period 10 cycles,
//     with no pulse shorter than 2 cycles at the switch.
//  3. cfg ch2 twice back-to-back -> cfg_ready=0 on 2nd until apply, 2nd value applied next wrap.
//  4. cfg ch0 D=0 -> clk_out[0] frozen, tick[0]=0. cfg D=3 -> applied next cycle, toggles every 3.
//  5. en[3] 1->0->1 mid-count with D=4 -> clk_out[3]=0 while low; first toggle 4 cycles after.
//  6. rst_n=0 with pend[1]=1, D=7 -> pend=0, div=2 all; (SYNC_EN) sync_req aligns ch0..3 edges.

Source files
------------

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel, run-time programmable clock divider.
// Each channel produces a 50% duty square wave (period 2*D) and a one-cycle
// tick on every toggle. New divisors arrive through a valid/ready port, wait
// in a per-channel shadow register, and take effect only at a wrap edge. This
// keeps every pulse on clk_out full length.
// Optional feature: define CLK_DIV_SYNC_EN to add the sync_req input. sync_req
// restarts all running channels together, so their phases line up.
module clk_div_prog #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync_req,
`endif
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pend
);

    logic [CNT_W-1:0] div_q    [N_CH];
    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] shadow_q [N_CH];
    logic [N_CH-1:0]  accept;
    logic             sync_now;

`ifdef CLK_DIV_SYNC_EN
    assign sync_now = sync_req;
`else
    assign sync_now = 1'b0;
`endif

    // Ready follows the pending flag of the addressed channel; out-of-range channels are always ready (dropped)
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    // Per-channel handshake completion; a request to a channel with an update in flight is held off by cfg_ready
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
        end
    end

    // Counter, output toggle, and shadow-to-active divisor transfer for every channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                div_q[i]    <= CNT_W'(DEFAULT_DIV);
                cnt_q[i]    <= '0;
                shadow_q[i] <= CNT_W'(DEFAULT_DIV);
            end
            clk_out <= '0;
            tick    <= '0;
            pend    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!en[i]) begin
                    // Idle channel: nothing is in flight, so a pending divisor can be taken at once
                    cnt_q[i]   <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                    if (pend[i]) begin
                        div_q[i] <= shadow_q[i];
                        pend[i]  <= 1'b0;
                    end
                end else if (div_q[i] == '0) begin
                    // Halted: clk_out keeps its level until a non-zero divisor arrives
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                    if (pend[i]) begin
                        div_q[i] <= shadow_q[i];
                        pend[i]  <= 1'b0;
                    end
                end else if (sync_now) begin
                    cnt_q[i]   <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                    if (pend[i]) begin
                        div_q[i] <= shadow_q[i];
                        pend[i]  <= 1'b0;
                    end
                end else if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
                    // Wrap: the half-period boundary, the only safe point to switch divisor
                    cnt_q[i]   <= '0;
                    clk_out[i] <= ~clk_out[i];
                    tick[i]    <= 1'b1;
                    if (pend[i]) begin
                        div_q[i] <= shadow_q[i];
                        pend[i]  <= 1'b0;
                    end
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    tick[i]  <= 1'b0;
                end

                // Accept and apply cannot coincide: accept needs pend low, apply needs pend high
                if (accept[i]) begin
                    shadow_q[i] <= cfg_div;
                    pend[i]     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog. The reference model works with edge timestamps:
// it predicts the edge index of each channel's next toggle. It does not model
// a counter.
module tb_clk_div_prog;

    localparam int N_CH  = 4;
    localparam int CNT_W = 32;
    localparam int DEF   = 2;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_CH-1:0]  en = '0;
    logic             sync_req = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  pend;

    int n_cmp = 0;
    int n_err = 0;

    clk_div_prog #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
`ifdef CLK_DIV_SYNC_EN
        .sync_req  (sync_req),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick),
        .pend      (pend)
    );

    always #5 clk = ~clk;

    // Reference model state
    int t = 0;
    int m_div  [N_CH];
    int m_sh   [N_CH];
    int m_next [N_CH];
    bit m_pend [N_CH];
    bit m_run  [N_CH];
    bit m_clk  [N_CH];
    bit m_tick [N_CH];

    function automatic bit model_ready();
        if (int'(cfg_ch) >= N_CH) return 1'b1;
        return !m_pend[int'(cfg_ch)];
    endfunction

    function automatic logic [N_CH-1:0] pack(input bit v [N_CH]);
        logic [N_CH-1:0] r;
        for (int i = 0; i < N_CH; i++) r[i] = v[i];
        return r;
    endfunction

    // Advance the model across one rising edge, using the inputs presented before that edge
    function automatic void model_edge();
        bit acc, ap, restart;
        t++;
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                m_div[c] = DEF; m_sh[c] = DEF; m_pend[c] = 0;
                m_run[c] = 0; m_clk[c] = 0; m_tick[c] = 0; m_next[c] = 0;
            end
            return;
        end
        for (int c = 0; c < N_CH; c++) begin
            acc = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
            ap = 0;
            restart = 0;
            m_tick[c] = 0;
            if (!en[c]) begin
                m_clk[c] = 0; m_run[c] = 0; ap = m_pend[c];
            end else if (m_div[c] == 0) begin
                m_run[c] = 0; ap = m_pend[c];
            end else if (sync_req) begin
                m_clk[c] = 0; ap = m_pend[c]; restart = 1;
            end else begin
                // First enabled edge counts as cycle 1; the toggle lands D edges in
                if (!m_run[c]) begin
                    m_run[c] = 1;
                    m_next[c] = t + m_div[c] - 1;
                end
                if (t == m_next[c]) begin
                    m_clk[c] = !m_clk[c]; m_tick[c] = 1; ap = m_pend[c]; restart = 1;
                end
            end
            if (ap) begin
                m_div[c] = m_sh[c];
                m_pend[c] = 0;
            end
            if (restart) begin
                m_run[c] = 1;
                m_next[c] = t + m_div[c];
            end
            if (acc) begin
                m_sh[c] = int'(cfg_div);
                m_pend[c] = 1;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, t);
        end
    endtask

    // One clock: check combinational ready, step model, then check registered outputs after the edge
    task automatic step(input bit chk = 1'b1);
        #2;
        if (chk) check("cfg_ready", {31'b0, cfg_ready}, {31'b0, model_ready()});
        model_edge();
        @(posedge clk);
        #1;
        if (chk) begin
            check("clk_out", {28'b0, clk_out}, {28'b0, pack(m_clk)});
            check("tick",    {28'b0, tick},    {28'b0, pack(m_tick)});
            check("pend",    {28'b0, pend},    {28'b0, pack(m_pend)});
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Present a request and hold it until the model says it is taken, bounded
    task automatic cfg_req(input int ch, input int d);
        bit taken;
        int k;
        taken = 0;
        k = 0;
        cfg_valid = 1'b1;
        cfg_ch = CH_W'(ch);
        cfg_div = CNT_W'(d);
        while (!taken && k < 40) begin
            #2;
            taken = model_ready();
            #0;
            step();
            k++;
        end
        cfg_valid = 1'b0;
        if (!taken) begin
            n_cmp++;
            n_err++;
            $error("FAIL cfg_timeout ch=%0d observed=not_accepted expected=accepted", ch);
        end
    endtask

    initial begin
        // Reset while the DUT state is still unknown
        rst_n = 1'b0;
        step(1'b0);
        step(1'b0);
        step();
        check("reset_clk_out", {28'b0, clk_out}, 32'h0);
        check("reset_pend",    {28'b0, pend},    32'h0);

        // 1: default divisor, all channels running
        rst_n = 1'b1;
        en = 4'hF;
        run(12);

        // 2: ch1 -> D=5 mid-period
        run(1);
        cfg_req(1, 5);
        run(25);

        // 3: two updates to ch2 back to back; the second is held off until the first applies
        cfg_req(2, 3);
        cfg_req(2, 4);
        run(20);

        // 4: halt ch0, then restart it with D=3
        cfg_req(0, 0);
        run(6);
        cfg_req(0, 3);
        run(12);

        // 5: ch3 D=4, enable drop mid-count
        cfg_req(3, 4);
        run(9);
        en[3] = 1'b0;
        run(3);
        en[3] = 1'b1;
        run(12);

        // 6: reset with an update pending on ch1
        cfg_req(1, 7);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(8);
        cfg_req(1, 1);
        run(6);

`ifdef CLK_DIV_SYNC_EN
        cfg_req(2, 3);
        cfg_req(3, 5);
        run(7);
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        run(20);
`endif

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            bit acc;
            if ($urandom_range(0, 9) == 0) begin
                int c;
                c = int'($urandom_range(0, N_CH - 1));
                en[c] = ~en[c];
            end
            if (!cfg_valid && $urandom_range(0, 3) == 0) begin
                cfg_valid = 1'b1;
                cfg_ch = CH_W'($urandom_range(0, N_CH - 1));
                cfg_div = CNT_W'($urandom_range(0, 6));
            end
`ifdef CLK_DIV_SYNC_EN
            sync_req = ($urandom_range(0, 39) == 0);
`endif
            rst_n = ($urandom_range(0, 249) != 0);
            acc = cfg_valid && model_ready() && rst_n;
            step();
            if (acc) cfg_valid = 1'b0;
        end
        rst_n = 1'b1;
        sync_req = 1'b0;
        cfg_valid = 1'b0;
        run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
